// File: rtl/axicb_mst_switch_wr_gen.sv
// Write-path master switch: round-robin AW arbitration with per-master outstanding limits,
// W steering in AW-acceptance order, and B routing by ID mask with unrouted-response draining.
module axicb_mst_switch_wr_gen #(
   parameter int AXI_ID_W    = 8,
   parameter int MST_NB      = 4,
   parameter logic [MST_NB*AXI_ID_W-1:0] MST_ID_MASK = {8'h30, 8'h20, 8'h10, 8'h00},
   parameter int MAX_OSTD    = 4,
   parameter int WFIFO_DEPTH = 8,
   parameter int AWCH_W      = 8,
   parameter int WCH_W       = 8,
   parameter int BCH_W       = 8
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic                     srst,
   input  logic [MST_NB-1:0]        i_awvalid,
   output logic [MST_NB-1:0]        i_awready,
   input  logic [MST_NB*AWCH_W-1:0] i_awch,
   input  logic [MST_NB-1:0]        i_wvalid,
   output logic [MST_NB-1:0]        i_wready,
   input  logic [MST_NB-1:0]        i_wlast,
   input  logic [MST_NB*WCH_W-1:0]  i_wch,
   output logic [MST_NB-1:0]        i_bvalid,
   input  logic [MST_NB-1:0]        i_bready,
   output logic [BCH_W-1:0]         i_bch,
   output logic                     o_awvalid,
   input  logic                     o_awready,
   output logic [AWCH_W-1:0]        o_awch,
   output logic                     o_wvalid,
   input  logic                     o_wready,
   output logic                     o_wlast,
   output logic [WCH_W-1:0]         o_wch,
   input  logic                     o_bvalid,
   output logic                     o_bready,
   input  logic [BCH_W-1:0]         o_bch,
   output logic                     err_unrouted
);

   localparam int GIDX_W = (MST_NB > 1) ? $clog2(MST_NB) : 1;
   localparam int CNT_W  = $clog2(MAX_OSTD + 1);
   localparam int PTR_W  = $clog2(WFIFO_DEPTH);
   localparam logic [PTR_W:0]   PTR_ONE = (PTR_W + 1)'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OSTD);

   logic                in_rst;
   logic [MST_NB-1:0]   elig;
   logic [CNT_W-1:0]    ostd_cnt [MST_NB];
   logic [GIDX_W-1:0]   ptr, lock_idx, rr_idx, grant, head, b_tgt;
   logic                lock, rr_hit, grant_hit, aw_hs, b_hit, b_hs, fifo_pop;
   logic [GIDX_W-1:0]   fifo_mem [WFIFO_DEPTH];
   logic [PTR_W:0]      wr_ptr, rd_ptr;
   logic                fifo_empty, fifo_full;

   function automatic logic [GIDX_W-1:0] wrap_add(input logic [GIDX_W-1:0] a, input int k);
      int s;
      s = int'(a) + k;
      if (s >= MST_NB) s = s - MST_NB;
      return GIDX_W'(s);
   endfunction

   assign in_rst     = !aresetn || srst;
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];

   always_comb begin
      for (int i = 0; i < MST_NB; i++)
         elig[i] = i_awvalid[i] && (ostd_cnt[i] < CNT_MAX);
   end

   // NOTE: every combinational output gets a default before the loop so no path leaves it unassigned (no latch).
   always_comb begin
      rr_hit = 1'b0;
      rr_idx = '0;
      for (int k = 0; k < MST_NB; k++) begin
         if (!rr_hit && elig[wrap_add(ptr, k)]) begin
            rr_hit = 1'b1;
            rr_idx = wrap_add(ptr, k);
         end
      end
   end

   // A stalled request keeps its grant so o_awch cannot change under a late-arriving master.
   assign grant     = lock ? lock_idx : rr_idx;
   assign grant_hit = lock ? elig[lock_idx] : rr_hit;
   assign o_awvalid = grant_hit && !fifo_full && !in_rst;
   assign o_awch    = i_awch[grant*AWCH_W +: AWCH_W];
   assign aw_hs     = o_awvalid && o_awready;
   assign i_awready = (o_awready && grant_hit && !fifo_full && !in_rst) ?
                      (MST_NB'(1) << grant) : '0;

   always_comb begin
      o_wvalid = 1'b0;
      o_wlast  = 1'b0;
      o_wch    = '0;
      i_wready = '0;
      if (!fifo_empty) begin
         o_wvalid       = i_wvalid[head];
         o_wlast        = i_wlast[head];
         o_wch          = i_wch[head*WCH_W +: WCH_W];
         i_wready[head] = o_wready;
      end
   end
   assign fifo_pop = o_wvalid && o_wready && o_wlast;

   // Descending scan so the lowest matching master wins.
   always_comb begin
      b_hit = 1'b0;
      b_tgt = '0;
      for (int i = MST_NB - 1; i >= 0; i--) begin
         if ((o_bch[AXI_ID_W-1:0] & MST_ID_MASK[i*AXI_ID_W +: AXI_ID_W]) ==
             MST_ID_MASK[i*AXI_ID_W +: AXI_ID_W]) begin
            b_hit = 1'b1;
            b_tgt = GIDX_W'(i);
         end
      end
      i_bvalid = '0;
      if (b_hit) i_bvalid[b_tgt] = o_bvalid;
   end
   assign o_bready = b_hit ? i_bready[b_tgt] : 1'b1;
   assign i_bch    = o_bch;
   assign b_hs     = o_bvalid && o_bready && b_hit;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         ptr          <= '0;
         lock         <= 1'b0;
         lock_idx     <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         err_unrouted <= 1'b0;
         for (int i = 0; i < MST_NB; i++) ostd_cnt[i] <= '0;
      end else if (srst) begin
         ptr          <= '0;
         lock         <= 1'b0;
         lock_idx     <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         err_unrouted <= 1'b0;
         for (int i = 0; i < MST_NB; i++) ostd_cnt[i] <= '0;
      end else begin
         err_unrouted <= o_bvalid && !b_hit;
         if (aw_hs) begin
            ptr    <= wrap_add(grant, 1);
            lock   <= 1'b0;
            wr_ptr <= wr_ptr + PTR_ONE;
         end else if (o_awvalid) begin
            lock     <= 1'b1;
            lock_idx <= grant;
         end
         if (fifo_pop) rd_ptr <= rd_ptr + PTR_ONE;
         for (int i = 0; i < MST_NB; i++) begin
            // Decrement saturates at zero: a stray B cannot underflow the count.
            if ((aw_hs && grant == GIDX_W'(i)) &&
                !(b_hs && b_tgt == GIDX_W'(i) && ostd_cnt[i] != '0))
               ostd_cnt[i] <= ostd_cnt[i] + CNT_ONE;
            else if (!(aw_hs && grant == GIDX_W'(i)) &&
                     (b_hs && b_tgt == GIDX_W'(i) && ostd_cnt[i] != '0))
               ostd_cnt[i] <= ostd_cnt[i] - CNT_ONE;
         end
      end
   end

   // NOTE: the grant-order storage is not reset; only the pointers define which entries are valid.
   always_ff @(posedge aclk) begin
      if (aw_hs) fifo_mem[wr_ptr[PTR_W-1:0]] <= grant;
   end

endmodule

// File: tb/tb_axicb_mst_switch_wr_gen.sv
// Directed bench for axicb_mst_switch_wr_gen: AW/W payloads checked by a scoreboard monitor,
// control signals checked inline at the falling edge.
module tb_axicb_mst_switch_wr_gen;

   localparam int NB = 4;

   logic           aclk, aresetn, srst;
   logic [NB-1:0]  i_awvalid, i_awready, i_wvalid, i_wready, i_wlast, i_bvalid, i_bready;
   logic [NB*8-1:0] i_awch, i_wch;
   logic [9:0]     i_bch, o_bch;
   logic           o_awvalid, o_awready, o_wvalid, o_wready, o_wlast;
   logic           o_bvalid, o_bready, err_unrouted;
   logic [7:0]     o_awch, o_wch;

   logic [7:0] aw_exp[$];
   logic [7:0] w_exp[$];
   int checks = 0;
   int errors = 0;

   axicb_mst_switch_wr_gen #(
      .AXI_ID_W(8), .MST_NB(NB),
      .MST_ID_MASK({8'h40, 8'h20, 8'h10, 8'h08}),
      .MAX_OSTD(2), .WFIFO_DEPTH(2),
      .AWCH_W(8), .WCH_W(8), .BCH_W(10)
   ) dut (
      .aclk(aclk), .aresetn(aresetn), .srst(srst),
      .i_awvalid(i_awvalid), .i_awready(i_awready), .i_awch(i_awch),
      .i_wvalid(i_wvalid), .i_wready(i_wready), .i_wlast(i_wlast), .i_wch(i_wch),
      .i_bvalid(i_bvalid), .i_bready(i_bready), .i_bch(i_bch),
      .o_awvalid(o_awvalid), .o_awready(o_awready), .o_awch(o_awch),
      .o_wvalid(o_wvalid), .o_wready(o_wready), .o_wlast(o_wlast), .o_wch(o_wch),
      .o_bvalid(o_bvalid), .o_bready(o_bready), .o_bch(o_bch),
      .err_unrouted(err_unrouted)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge aclk);
      #1;
   endtask

   // Scoreboard: every forwarded AW/W handshake must match the next queued expectation.
   always @(negedge aclk) begin
      if (aresetn && o_awvalid && o_awready) begin
         if (aw_exp.size() > 0) check("aw_payload", 32'(o_awch), 32'(aw_exp.pop_front()));
         else                   check("aw_unexpected", 32'(o_awch), 32'hFFFF_FFFF);
      end
      if (aresetn && o_wvalid && o_wready) begin
         if (w_exp.size() > 0) check("w_payload", 32'(o_wch), 32'(w_exp.pop_front()));
         else                  check("w_unexpected", 32'(o_wch), 32'hFFFF_FFFF);
      end
   end

   initial begin
      aresetn = 1'b0; srst = 1'b0;
      i_awch  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      i_wch   = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
      i_awvalid = 4'hF; i_wvalid = 4'hF; i_wlast = 4'hF; i_bready = '0;
      o_awready = 1'b1; o_wready = 1'b1; o_bvalid = 1'b0; o_bch = '0;

      // Reset held with every master requesting.
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      check("rst_awvalid", 32'(o_awvalid), 32'd0);
      check("rst_wvalid", 32'(o_wvalid), 32'd0);
      check("rst_err", 32'(err_unrouted), 32'd0);
      check("rst_awready", 32'(i_awready), 32'd0);
      check("rst_wready", 32'(i_wready), 32'd0);

      // Fairness: 5 grants 0,1,2,3,0; each W follows one cycle after its AW.
      next_cycle();
      aresetn = 1'b1;
      aw_exp.push_back(8'hA0); aw_exp.push_back(8'hA1); aw_exp.push_back(8'hA2);
      aw_exp.push_back(8'hA3); aw_exp.push_back(8'hA0);
      w_exp.push_back(8'hB0); w_exp.push_back(8'hB1); w_exp.push_back(8'hB2);
      w_exp.push_back(8'hB3); w_exp.push_back(8'hB0);
      @(negedge aclk);
      check("first_grant", 32'(i_awready), 32'b0001);
      check("first_no_w", 32'(o_wvalid), 32'd0);
      repeat (5) @(posedge aclk);
      #1;
      i_awvalid = '0;
      next_cycle();
      i_wvalid = '0; i_wlast = '0;
      srst = 1'b1;
      next_cycle();
      srst = 1'b0;

      // Lock: master 2 stalled 3 cycles; master 0 arriving later must not steal the grant.
      i_awvalid = 4'b0100; o_awready = 1'b0;
      @(negedge aclk);
      check("stall0_awch", 32'(o_awch), 32'hA2);
      check("stall0_awvalid", 32'(o_awvalid), 32'd1);
      next_cycle();
      i_awvalid = 4'b0101;
      @(negedge aclk);
      check("stall1_lock", 32'(o_awch), 32'hA2);
      next_cycle();
      @(negedge aclk);
      check("stall2_lock", 32'(o_awch), 32'hA2);
      next_cycle();
      o_awready = 1'b1;
      aw_exp.push_back(8'hA2);
      @(negedge aclk);
      check("lock_release", 32'(i_awready), 32'b0100);
      next_cycle();
      i_awvalid = 4'b0001;
      aw_exp.push_back(8'hA0);
      @(negedge aclk);
      check("after_lock_m0", 32'(i_awready), 32'b0001);
      next_cycle();

      // Order [2,0] fills the FIFO; master 0 W waits behind master 2's burst, master 1 AW waits for space.
      i_awvalid = 4'b0010; o_awready = 1'b1;
      i_wvalid = 4'b0001; i_wlast = 4'b0001; i_wch[7:0] = 8'h0F;
      @(negedge aclk);
      check("w_order_stall", 32'(i_wready), 32'b0100);
      check("w_order_novalid", 32'(o_wvalid), 32'd0);
      check("fifo_full_awvalid", 32'(o_awvalid), 32'd0);
      check("fifo_full_awready", 32'(i_awready), 32'd0);
      for (int k = 0; k < 4; k++) begin
         next_cycle();
         i_wvalid = 4'b0101;
         i_wch[23:16] = 8'(8'h20 + k);
         i_wlast[2] = (k == 3);
         w_exp.push_back(8'(8'h20 + k));
         @(negedge aclk);
         check("w_m2_beat_ready", 32'(i_wready), 32'b0100);
         check("w_m2_beat_last", 32'(o_wlast), 32'(k == 3));
      end
      next_cycle();
      i_wvalid = 4'b0001; i_wlast = 4'b0001;
      w_exp.push_back(8'h0F);
      aw_exp.push_back(8'hA1);
      @(negedge aclk);
      check("w_m0_after_burst", 32'(i_wready), 32'b0001);
      check("aw_after_pop", 32'(i_awready), 32'b0010);
      next_cycle();
      i_awvalid = '0;
      i_wvalid = 4'b0010; i_wlast = 4'b0010; i_wch[15:8] = 8'h1F;
      w_exp.push_back(8'h1F);
      next_cycle();
      i_wvalid = '0; i_wlast = '0;
      srst = 1'b1;
      next_cycle();
      srst = 1'b0;

      // Outstanding limit: master 1 gets two AWs, the third waits for a B with ID 'h10.
      i_awvalid = 4'b0010; i_wvalid = 4'b0010; i_wlast = 4'b0010;
      aw_exp.push_back(8'hA1); aw_exp.push_back(8'hA1);
      w_exp.push_back(8'h1F); w_exp.push_back(8'h1F);
      next_cycle();
      next_cycle();
      @(negedge aclk);
      check("ostd_limit_awvalid", 32'(o_awvalid), 32'd0);
      check("ostd_limit_awready", 32'(i_awready), 32'd0);
      next_cycle();
      i_wvalid = '0; i_wlast = '0;
      o_bvalid = 1'b1; o_bch = {2'b00, 8'h10}; i_bready = '0;
      @(negedge aclk);
      check("b_route_m1", 32'(i_bvalid), 32'b0010);
      check("b_backpressure", 32'(o_bready), 32'd0);
      check("b_bch", 32'(i_bch), 32'h010);
      check("ostd_hold_awvalid", 32'(o_awvalid), 32'd0);
      next_cycle();
      i_bready = 4'b0010;
      @(negedge aclk);
      check("b_ready_m1", 32'(o_bready), 32'd1);
      check("ostd_same_cycle", 32'(o_awvalid), 32'd0);
      next_cycle();
      o_bvalid = 1'b0; i_bready = '0;
      aw_exp.push_back(8'hA1);
      @(negedge aclk);
      check("ostd_reeligible", 32'(i_awready), 32'b0010);
      next_cycle();
      i_awvalid = '0;
      i_wvalid = 4'b0010; i_wlast = 4'b0010;
      w_exp.push_back(8'h1F);
      next_cycle();
      i_wvalid = '0; i_wlast = '0;

      // ID 'h30 matches masters 1 and 2; the lowest wins.
      o_bvalid = 1'b1; o_bch = {2'b00, 8'h30};
      @(negedge aclk);
      check("b_lowest_match", 32'(i_bvalid), 32'b0010);
      next_cycle();

      // Unrouted ID 'h00: drained and flagged for exactly one cycle.
      o_bch = {2'b10, 8'h00};
      @(negedge aclk);
      check("unrouted_bvalid", 32'(i_bvalid), 32'd0);
      check("unrouted_bready", 32'(o_bready), 32'd1);
      check("unrouted_err_now", 32'(err_unrouted), 32'd0);
      next_cycle();
      o_bvalid = 1'b0;
      @(negedge aclk);
      check("unrouted_err_pulse", 32'(err_unrouted), 32'd1);
      next_cycle();
      @(negedge aclk);
      check("unrouted_err_clear", 32'(err_unrouted), 32'd0);

      next_cycle();
      check("aw_queue_drained", 32'(aw_exp.size()), 32'd0);
      check("w_queue_drained", 32'(w_exp.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
